// File: rtl/bus_periph_responder.sv
// Memory-mapped peripheral responder for the CPU data bus I/O window.
// Provides LED, switch/button, seven-segment scanner and (optionally) a timer.
// Optional feature macro: PERIPH_TIMER_EN builds TCNT/TDIV and the prescaler.
module bus_periph_responder #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_F000,
  parameter int unsigned SCAN_DIV  = 20000
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic [31:0] Bus_addr,
  input  logic        Bus_we,
  input  logic [31:0] Bus_wdata,
  output logic [31:0] Bus_rdata,
  output logic        periph_sel,
  input  logic [23:0] sw,
  input  logic [4:0]  btn,
  output logic [23:0] led,
  output logic [7:0]  dig_en,
  output logic [7:0]  dig_seg
);

  localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_DIV - 1);

  // Word offsets within the window (byte offset >> 2).
  localparam logic [9:0] OffDig  = 10'h000;
  localparam logic [9:0] OffTcnt = 10'h008;
  localparam logic [9:0] OffTdiv = 10'h009;
  localparam logic [9:0] OffLed  = 10'h018;
  localparam logic [9:0] OffSw   = 10'h01C;
  localparam logic [9:0] OffBtn  = 10'h01E;

  // Active-low seven-segment pattern {dp,g,f,e,d,c,b,a}; dp always off.
  function automatic logic [7:0] hex2seg(input logic [3:0] hex);
    logic [7:0] seg;
    case (hex)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

  logic [9:0]  word_addr;
  logic        wr_en;
  logic        unused_addr;

  logic [31:0] dig_q, dig_d;
  logic [23:0] led_q, led_d;
  logic [23:0] sw_meta_q, sw_sync_q;
  logic [4:0]  btn_meta_q, btn_sync_q;
  logic [ScanW-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  dig_en_q, dig_en_d;
  logic [7:0]  dig_seg_q, dig_seg_d;

  assign periph_sel  = (Bus_addr[31:12] == BASE_ADDR[31:12]);
  assign word_addr   = Bus_addr[11:2];
  assign wr_en       = Bus_we & periph_sel;
  // Byte lane bits are ignored; only full-word accesses are supported.
  assign unused_addr = ^Bus_addr[1:0];

  assign led     = led_q;
  assign dig_en  = dig_en_q;
  assign dig_seg = dig_seg_q;

`ifdef PERIPH_TIMER_EN
  logic [31:0] tcnt_q, tcnt_d;
  logic [31:0] tdiv_q, tdiv_d;
  logic [31:0] presc_q, presc_d;

  // Timer next state; a TCNT write overrides the increment, a TDIV write suppresses it.
  always_comb begin
    tcnt_d  = tcnt_q;
    tdiv_d  = tdiv_q;
    presc_d = presc_q + 32'd1;
    if (presc_q == tdiv_q) begin
      presc_d = '0;
      tcnt_d  = tcnt_q + 32'd1;
    end
    if (wr_en && word_addr == OffTdiv) begin
      tdiv_d  = Bus_wdata;
      presc_d = '0;
      tcnt_d  = tcnt_q;
    end
    if (wr_en && word_addr == OffTcnt) begin
      tcnt_d = Bus_wdata;
    end
  end

  // Timer state registers.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      tcnt_q  <= '0;
      tdiv_q  <= '0;
      presc_q <= '0;
    end else begin
      tcnt_q  <= tcnt_d;
      tdiv_q  <= tdiv_d;
      presc_q <= presc_d;
    end
  end
`endif

  // Combinational read mux; zero when unselected or unmapped.
  always_comb begin
    Bus_rdata = '0;
    if (periph_sel) begin
      case (word_addr)
        OffDig:  Bus_rdata = dig_q;
`ifdef PERIPH_TIMER_EN
        OffTcnt: Bus_rdata = tcnt_q;
        OffTdiv: Bus_rdata = tdiv_q;
`endif
        OffLed:  Bus_rdata = {8'h00, led_q};
        OffSw:   Bus_rdata = {8'h00, sw_sync_q};
        OffBtn:  Bus_rdata = {27'h0, btn_sync_q};
        default: Bus_rdata = '0;
      endcase
    end
  end

  // Writable register next state and scanner next state.
  always_comb begin
    dig_d = dig_q;
    led_d = led_q;
    if (wr_en && word_addr == OffDig) dig_d = Bus_wdata;
    if (wr_en && word_addr == OffLed) led_d = Bus_wdata[23:0];

    scan_cnt_d = scan_cnt_q + ScanW'(1);
    idx_d      = idx_q;
    if (scan_cnt_q == ScanLast) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 3'd1;
    end
    dig_en_d  = ~(8'b1 << idx_q);
    dig_seg_d = hex2seg(dig_q[{idx_q, 2'b00} +: 4]);
  end

  // Register state, synchronisers and scanner outputs.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      dig_q      <= '0;
      led_q      <= '0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      dig_en_q   <= 8'hFF;
      dig_seg_q  <= 8'hFF;
    end else begin
      dig_q      <= dig_d;
      led_q      <= led_d;
      sw_meta_q  <= sw;
      sw_sync_q  <= sw_meta_q;
      btn_meta_q <= btn;
      btn_sync_q <= btn_meta_q;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      dig_en_q   <= dig_en_d;
      dig_seg_q  <= dig_seg_d;
    end
  end

endmodule

// File: tb/tb_bus_periph_responder.sv
// Directed self-checking bench for bus_periph_responder (SCAN_DIV = 4).
module tb_bus_periph_responder;

  logic        clk;
  logic        rst_n;
  logic [31:0] Bus_addr;
  logic        Bus_we;
  logic [31:0] Bus_wdata;
  logic [31:0] Bus_rdata;
  logic        periph_sel;
  logic [23:0] sw;
  logic [4:0]  btn;
  logic [23:0] led;
  logic [7:0]  dig_en;
  logic [7:0]  dig_seg;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] en_tab  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [7:0] seg_tab [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

  bus_periph_responder #(
    .BASE_ADDR (32'hFFFF_F000),
    .SCAN_DIV  (4)
  ) dut (
    .cpu_clk    (clk),
    .cpu_rst    (rst_n),
    .Bus_addr   (Bus_addr),
    .Bus_we     (Bus_we),
    .Bus_wdata  (Bus_wdata),
    .Bus_rdata  (Bus_rdata),
    .periph_sel (periph_sel),
    .sw         (sw),
    .btn        (btn),
    .led        (led),
    .dig_en     (dig_en),
    .dig_seg    (dig_seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges counted since reset release; scanner digit = (cyc-1)/4 mod 8.
  always @(posedge clk) if (rst_n) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the following negedge after one posedge.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    Bus_addr  = addr;
    Bus_wdata = data;
    Bus_we    = 1'b1;
    @(negedge clk);
    Bus_we    = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    Bus_addr = addr;
    #1;
    chk(tag, Bus_rdata, exp);
  endtask

  initial begin
    rst_n     = 1'b0;
    Bus_addr  = 32'h0;
    Bus_we    = 1'b0;
    Bus_wdata = 32'h0;
    sw        = '0;
    btn       = '0;
    repeat (3) @(negedge clk);

    chk("rst_led", {8'h0, led}, 32'h0);
    chk("rst_dig_en", {24'h0, dig_en}, 32'hFF);
    chk("rst_dig_seg", {24'h0, dig_seg}, 32'hFF);

    rst_n = 1'b1;
    #1;
    chk("rel_dig_en_pre", {24'h0, dig_en}, 32'hFF);
    @(negedge clk);
    chk("first_dig_en", {24'h0, dig_en}, 32'hFE);
    chk("first_dig_seg", {24'h0, dig_seg}, 32'hC0);
    chk("first_led", {8'h0, led}, 32'h0);
    rd("rd_led_rst", 32'hFFFF_F060, 32'h0);
    rd("rd_unmapped", 32'hFFFF_F100, 32'h0);
    rd("rd_outside", 32'hFFFF_E000, 32'h0);
    chk("sel_outside", {31'h0, periph_sel}, 32'h0);
    rd("rd_dig_base", 32'hFFFF_F000, 32'h0);
    chk("sel_inside", {31'h0, periph_sel}, 32'h1);

    // LED register write, readback and byte-offset aliasing.
    bus_write(32'hFFFF_F060, 32'hDEAD_BEEF);
    chk("led_pin", {8'h0, led}, 32'h00AD_BEEF);
    rd("rd_led", 32'hFFFF_F060, 32'h00AD_BEEF);
    rd("rd_led_low2", 32'hFFFF_F063, 32'h00AD_BEEF);
    bus_write(32'hFFFF_E060, 32'h0000_1234);
    chk("led_unsel_wr", {8'h0, led}, 32'h00AD_BEEF);
    bus_write(32'hFFFF_F104, 32'hFFFF_FFFF);
    rd("rd_unmapped_wr", 32'hFFFF_F104, 32'h0);

    // Scanner: each digit held 4 cycles, nibble k -> digit k.
    bus_write(32'hFFFF_F000, 32'h7654_3210);
    rd("rd_dig", 32'hFFFF_F000, 32'h7654_3210);
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      chk("scan_en", {24'h0, dig_en}, {24'h0, en_tab[((cyc - 1) / 4) % 8]});
      chk("scan_seg", {24'h0, dig_seg}, {24'h0, seg_tab[((cyc - 1) / 4) % 8]});
    end
    // DIG=FFFFFFFF -> every digit shows 'F' (8E) one cycle after the write.
    bus_write(32'hFFFF_F000, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("scan_seg_F", {24'h0, dig_seg}, 32'h8E);
    bus_write(32'hFFFF_F000, 32'hAAAA_AAAA);
    @(negedge clk);
    chk("scan_seg_A", {24'h0, dig_seg}, 32'h88);

    // Synchronisers: two-edge latency, read-only.
    sw  = 24'h00A5A5;
    btn = 5'b10011;
    rd("sw_old0", 32'hFFFF_F070, 32'h0);
    rd("btn_old0", 32'hFFFF_F078, 32'h0);
    @(negedge clk);
    rd("sw_old1", 32'hFFFF_F070, 32'h0);
    rd("btn_old1", 32'hFFFF_F078, 32'h0);
    @(negedge clk);
    rd("sw_new", 32'hFFFF_F070, 32'h0000_A5A5);
    rd("btn_new", 32'hFFFF_F078, 32'h0000_0013);
    bus_write(32'hFFFF_F070, 32'hFFFF_FFFF);
    rd("sw_ro", 32'hFFFF_F070, 32'h0000_A5A5);
    bus_write(32'hFFFF_F078, 32'h0000_0000);
    rd("btn_ro", 32'hFFFF_F078, 32'h0000_0013);

`ifdef PERIPH_TIMER_EN
    bus_write(32'hFFFF_F020, 32'h0);
    bus_write(32'hFFFF_F024, 32'h2);
    rd("tdiv_rd", 32'hFFFF_F024, 32'h2);
    rd("tcnt_k0", 32'hFFFF_F020, 32'h0);
    @(negedge clk); rd("tcnt_k1", 32'hFFFF_F020, 32'h0);
    @(negedge clk); rd("tcnt_k2", 32'hFFFF_F020, 32'h0);
    @(negedge clk); rd("tcnt_k3", 32'hFFFF_F020, 32'h1);
    @(negedge clk); rd("tcnt_k4", 32'hFFFF_F020, 32'h1);
    @(negedge clk); rd("tcnt_k5", 32'hFFFF_F020, 32'h1);
    @(negedge clk); rd("tcnt_k6", 32'hFFFF_F020, 32'h2);
    repeat (2) @(negedge clk);
    // This edge carries a pending increment; the write must win.
    bus_write(32'hFFFF_F020, 32'hFFFF_FFFF);
    rd("tcnt_wr_win", 32'hFFFF_F020, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    rd("tcnt_hold", 32'hFFFF_F020, 32'hFFFF_FFFF);
    @(negedge clk);
    rd("tcnt_wrap", 32'hFFFF_F020, 32'h0);
`else
    bus_write(32'hFFFF_F020, 32'h5);
    rd("tcnt_absent", 32'hFFFF_F020, 32'h0);
    bus_write(32'hFFFF_F024, 32'h7);
    rd("tdiv_absent", 32'hFFFF_F024, 32'h0);
`endif

    // Asynchronous reset mid-run, away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_led", {8'h0, led}, 32'h0);
    chk("async_dig_en", {24'h0, dig_en}, 32'hFF);
    chk("async_dig_seg", {24'h0, dig_seg}, 32'hFF);
    rd("async_rd_dig", 32'hFFFF_F000, 32'h0);
    rd("async_rd_sw", 32'hFFFF_F070, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
